// File: rtl/toaplan2_sound_pkg.sv
// Shared types and defaults for the Toaplan2 dual-OKI sound path.
package toaplan2_sound_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StRetry
    } pcm_state_e;

    localparam int unsigned NREQ        = 2;
    localparam logic [19:0] DEF_BASE0   = 20'h00000;
    localparam logic [19:0] DEF_BASE1   = 20'h40000;
    localparam logic [7:0]  DEF_TIMEOUT = 8'd255;

endpackage

// File: rtl/toaplan2_pcm_slot.sv
// One requester's fetch result: last served address and byte, plus the ok/pending decode.
module toaplan2_pcm_slot #(
    parameter int unsigned AW = 18
) (
    input  logic          CLK96,
    input  logic          RESET96,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic          store,
    input  logic [AW-1:0] store_addr,
    input  logic [7:0]    store_data,
    output logic [7:0]    data,
    output logic          ok,
    output logic          pend
);

    logic [AW-1:0] served_addr_q;
    logic [7:0]    data_q;
    logic          valid_q;

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            served_addr_q <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
        end else if (store) begin
            served_addr_q <= store_addr;
            data_q        <= store_data;
            valid_q       <= 1'b1;
        end
    end

    // Combinational so ok drops in the same cycle the OKI moves its address.
    assign ok   = en & valid_q & (addr == served_addr_q);
    assign pend = en & ~ok;
    assign data = data_q;

endmodule

// File: rtl/toaplan2_pcm_arb.sv
// Round-robin arbiter sharing one PCM ROM port between two jt6295 cores, with a fetch watchdog.
module toaplan2_pcm_arb
    import toaplan2_sound_pkg::*;
#(
    parameter int unsigned       OKI_AW  = 18,
    parameter int unsigned       PCM_AW  = 20,
    parameter logic [PCM_AW-1:0] BASE0   = PCM_AW'(DEF_BASE0),
    parameter logic [PCM_AW-1:0] BASE1   = PCM_AW'(DEF_BASE1),
    parameter logic [7:0]        TIMEOUT = DEF_TIMEOUT
) (
    input  logic              CLK96,
    input  logic              RESET96,
    input  logic              OKI0_EN,
    input  logic              OKI1_EN,
    input  logic [OKI_AW-1:0] OKI0_ADDR,
    input  logic [OKI_AW-1:0] OKI1_ADDR,
    output logic [7:0]        OKI0_DATA,
    output logic [7:0]        OKI1_DATA,
    output logic              OKI0_OK,
    output logic              OKI1_OK,
    output logic              PCM_CS,
    output logic [PCM_AW-1:0] PCM_ADDR,
    input  logic [7:0]        PCM_DOUT,
    input  logic              PCM_OK,
    output logic              BUSY,
    output logic              TIMEOUT_P
);

    pcm_state_e        state_q;
    logic              g_q;
    logic              last_q;
    logic [OKI_AW-1:0] a_lat_q;
    logic [7:0]        wd_q;

    logic [NREQ-1:0]   pend;
    logic [NREQ-1:0]   ok;
    logic [NREQ-1:0]   store;
    logic              gnt;
    logic [OKI_AW-1:0] gnt_addr;
    logic [PCM_AW-1:0] gnt_pcm;

    assign OKI0_OK = ok[0];
    assign OKI1_OK = ok[1];

    assign store[0] = (state_q == StWait) & PCM_OK & ~g_q;
    assign store[1] = (state_q == StWait) & PCM_OK & g_q;

    toaplan2_pcm_slot #(
        .AW (OKI_AW)
    ) u_slot0 (
        .CLK96      (CLK96),
        .RESET96    (RESET96),
        .en         (OKI0_EN),
        .addr       (OKI0_ADDR),
        .store      (store[0]),
        .store_addr (a_lat_q),
        .store_data (PCM_DOUT),
        .data       (OKI0_DATA),
        .ok         (ok[0]),
        .pend       (pend[0])
    );

    toaplan2_pcm_slot #(
        .AW (OKI_AW)
    ) u_slot1 (
        .CLK96      (CLK96),
        .RESET96    (RESET96),
        .en         (OKI1_EN),
        .addr       (OKI1_ADDR),
        .store      (store[1]),
        .store_addr (a_lat_q),
        .store_data (PCM_DOUT),
        .data       (OKI1_DATA),
        .ok         (ok[1]),
        .pend       (pend[1])
    );

    // On a tie the requester not served last wins.
    assign gnt      = (pend[0] & pend[1]) ? ~last_q : pend[1];
    assign gnt_addr = gnt ? OKI1_ADDR : OKI0_ADDR;
    assign gnt_pcm  = PCM_AW'(gnt_addr) + (gnt ? BASE1 : BASE0);

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state_q   <= StIdle;
            g_q       <= 1'b0;
            last_q    <= 1'b1;
            a_lat_q   <= '0;
            wd_q      <= '0;
            PCM_CS    <= 1'b0;
            PCM_ADDR  <= '0;
            BUSY      <= 1'b0;
            TIMEOUT_P <= 1'b0;
        end else begin
            TIMEOUT_P <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|pend) begin
                        g_q      <= gnt;
                        a_lat_q  <= gnt_addr;
                        PCM_ADDR <= gnt_pcm;
                        PCM_CS   <= 1'b1;
                        BUSY     <= 1'b1;
                        state_q  <= StReq;
                    end
                end
                // An OK seen here may belong to a previous request, so it is ignored.
                StReq: begin
                    wd_q    <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (PCM_OK) begin
                        last_q  <= g_q;
                        PCM_CS  <= 1'b0;
                        BUSY    <= 1'b0;
                        state_q <= StIdle;
                    end else if (wd_q == TIMEOUT - 8'd1) begin
                        PCM_CS    <= 1'b0;
                        TIMEOUT_P <= 1'b1;
                        state_q   <= StRetry;
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
                end
                StRetry: begin
                    PCM_CS  <= 1'b1;
                    state_q <= StReq;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/toaplan2_pcm_arb.md
# toaplan2_pcm_arb

Two-requester arbiter that shares one PCM ROM (SDRAM) port between two jt6295 ADPCM cores, for Toaplan2 boards with dual OKI sound. Sits between the sound block's OKI `rom_addr`/`rom_data`/`rom_ok` pins and the `PCM_CS`/`PCM_ADDR`/`PCM_DOUT`/`PCM_OK` port. Each OKI keeps the jt6295 contract: `ok` is high only while the returned byte matches the address it is currently driving. Requests are served round-robin, and a watchdog reissues any fetch the memory controller drops.

## Interface
Parameters:
- `OKI_AW`, 18: address width from each OKI.
- `PCM_AW`, 20: PCM ROM address width.
- `BASE0`, 20'h00000: ROM offset added to OKI0 addresses.
- `BASE1`, 20'h40000: ROM offset added to OKI1 addresses.
- `TIMEOUT`, 8'd255: WAIT cycles without `PCM_OK` before a retry.

Ports:
- `CLK96`, in, 1: sole clock.
- `RESET96`, in, 1: synchronous, active-high reset.
- `OKI0_EN`, `OKI1_EN`, in, 1 each: requester enable. A disabled requester never requests and its `ok` is 0.
- `OKI0_ADDR`, `OKI1_ADDR`, in, `OKI_AW` each: jt6295 `rom_addr`.
- `OKI0_DATA`, `OKI1_DATA`, out, 8 each: jt6295 `rom_data`.
- `OKI0_OK`, `OKI1_OK`, out, 1 each: jt6295 `rom_ok`.
- `PCM_CS`, out, 1: ROM request.
- `PCM_ADDR`, out, `PCM_AW`: ROM address.
- `PCM_DOUT`, in, 8: ROM data.
- `PCM_OK`, in, 1: ROM data valid.
- `BUSY`, out, 1: FSM not in IDLE.
- `TIMEOUT_P`, out, 1: one-cycle pulse on each retry.

## Operation
- Per requester *i*: registers `served_addr[i]`, `data[i]`, `valid[i]`.
- `OKIi_OK` = `EN_i` & `valid[i]` & (`OKIi_ADDR` == `served_addr[i]`). The output is combinational, so it falls in the same cycle the OKI address changes.
- `OKIi_DATA` = `data[i]`.
- `pend[i]` = `EN_i` & !`OKIi_OK`.
- FSM states are IDLE, REQ, WAIT and RETRY. `last` records the last requester served.
- IDLE:
  - If exactly one requester is pending, grant it.
  - If both are pending, grant !`last`.
  - On grant, latch `g`, `a_lat` = `OKIg_ADDR`, and `PCM_ADDR` = `a_lat` zero-extended + `BASEg`, truncated to `PCM_AW`. Go to REQ.
- REQ: one cycle, `PCM_CS`=1, `PCM_OK` ignored (stale-OK blanking). Go to WAIT. Clear the watchdog counter.
- WAIT:
  - `PCM_CS`=1.
  - On `PCM_OK`: write `data[g]` ← `PCM_DOUT`, `served_addr[g]` ← `a_lat`, `valid[g]` ← 1, `last` ← `g`. Go to IDLE.
  - Else, when the counter reaches `TIMEOUT`: pulse `TIMEOUT_P` and go to RETRY.
- RETRY: one cycle, `PCM_CS`=0. Go to REQ with the same `g`/`a_lat`.
- If a requester's address changes mid-fetch, the fetch still completes and is stored. The compare then fails, so the requester becomes pending again and is re-served (no abort).
- If a requester's `EN` drops mid-fetch, the fetch completes and its result is stored, but `ok` stays 0.
- `PCM_ADDR` holds its value outside a fetch.
- Reset values:
  - FSM in IDLE.
  - `PCM_CS`=0, `PCM_ADDR`=0, `BUSY`=0, `TIMEOUT_P`=0.
  - `valid`=0, `data`=0, `served_addr`=0, `last`=1, so OKI0 wins the first tie.
  - All `OKIi_OK`=0.
- Reset mid-fetch returns to IDLE at once with `PCM_CS`=0. A `PCM_OK` arriving later is ignored.

## Timing
- Cycle 0, edge: the requester's address changes and the arbiter is in IDLE; it grants at this edge.
- Cycle 1: REQ, `PCM_CS`=1.
- Cycle 2 onward: WAIT.
- If `PCM_OK` is sampled at edge *k* (*k* ≥ 2), `OKIi_OK`=1 from cycle *k*+1. Minimum address-to-ok latency is 3 cycles.
- Back-to-back: IDLE holds one cycle between fetches. Alternating service gives each OKI a worst case of 2 fetches plus 2 IDLE cycles of wait, well inside the OKI sample period.
- `PCM_OK` seen during REQ or RETRY is ignored.
- The watchdog counts only in WAIT. A retry costs `TIMEOUT`+2 cycles.

## Structure
- Package `toaplan2_sound_pkg` holds:
  - the FSM state enum (IDLE/REQ/WAIT/RETRY);
  - `NREQ`=2;
  - the default `BASE0`/`BASE1`/`TIMEOUT` constants.
- Sub-module `toaplan2_pcm_slot` is instantiated once per requester. It holds `served_addr`/`data`/`valid`, the `ok` compare and `pend`, and has a store strobe input.
- The top level holds the FSM, the round-robin `last`, the address adder and the watchdog.

## Test plan
- Single requester: OKI0 (OKI1 disabled) → `OKI0_ADDR`=18'h00123, memory model returns 8'hA5 with `PCM_OK` 2 cycles after CS → `PCM_ADDR`=20'h00123, `OKI0_DATA`=8'hA5, `OKI0_OK` rises 4 cycles after the address change. Changing the address to 18'h00124 → `OKI0_OK` falls in the same cycle.
- Contention and offset: both OKIs change address in the same cycle after reset → OKI0 is served first, then OKI1 with `PCM_ADDR` = `OKI1_ADDR` + 20'h40000. Over a 1000-cycle stream, grants alternate strictly.
- Stale OK: `PCM_OK` held high across the REQ cycle → it is ignored, and the data is captured only on the WAIT-phase OK.
- Timeout: the memory model never asserts OK, with `TIMEOUT`=8'd10 → `TIMEOUT_P` pulses, CS is low for 1 cycle, the same address is reissued, and a later OK completes normally.
- Reset: `RESET96` pulsed during WAIT → next cycle `PCM_CS`=0 and both OKs are 0. A late `PCM_OK` stores nothing.
